// File: rtl/backend_ap_dispatcher_pkg.sv
// backend_ap_dispatcher_pkg: types shared by the backend dispatcher and the frontend command path
// Contents: ap_mode_t (auto-precharge policy), dispatch_entry_t (queued command at frontend widths).
package backend_ap_dispatcher_pkg;
    typedef enum logic [1:0] {
        AP_CLOSE     = 2'd0,
        AP_OPEN      = 2'd1,
        AP_LOOKAHEAD = 2'd2
    } ap_mode_t;

    localparam int CMD_BANK_BITS = 3;
    localparam int CMD_ROW_BITS  = 14;
    localparam int CMD_COL_BITS  = 10;
    localparam int CMD_DATA_BITS = 64;

    // Command record as the frontend delivers it; the dispatcher queue uses the
    // same field order, resized to the instance's parameters.
    typedef struct packed {
        logic                     op;
        logic [CMD_BANK_BITS-1:0] bank;
        logic [CMD_ROW_BITS-1:0]  row;
        logic [CMD_COL_BITS-1:0]  col;
        logic [CMD_DATA_BITS-1:0] wdata;
    } dispatch_entry_t;
endpackage

// File: rtl/backend_bank_tracker.sv
// backend_bank_tracker: per-bank open-row state and saturating row-hit/conflict/precharge counters
// Ports: clk, power_on_rst_n (async, active-low); issue/bank/row/ap describe the command leaving
// the dispatcher this cycle; row_hit_cnt, row_conflict_cnt, ap_cnt are the statistics.
module backend_bank_tracker
    import backend_ap_dispatcher_pkg::*;
#(
    parameter int NUM_BANKS = 8,
    parameter int ROW_BITS  = 14,
    parameter int CNT_BITS  = 16,
    localparam int BANK_BITS = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 power_on_rst_n,
    input  logic                 issue,
    input  logic [BANK_BITS-1:0] bank,
    input  logic [ROW_BITS-1:0]  row,
    input  logic                 ap,
    output logic [CNT_BITS-1:0]  row_hit_cnt,
    output logic [CNT_BITS-1:0]  row_conflict_cnt,
    output logic [CNT_BITS-1:0]  ap_cnt
);
    logic [NUM_BANKS-1:0] is_open;
    logic [ROW_BITS-1:0]  open_row [NUM_BANKS];
    logic                 hit, conflict;

    assign hit      = is_open[bank] && open_row[bank] == row;
    assign conflict = is_open[bank] && open_row[bank] != row;

    // Row value only matters while the bank is flagged open, so it needs no reset.
    always_ff @(posedge clk) begin
        if (issue && !ap) open_row[bank] <= row;
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            is_open          <= '0;
            row_hit_cnt      <= '0;
            row_conflict_cnt <= '0;
            ap_cnt           <= '0;
        end else if (issue) begin
            is_open[bank] <= !ap;
            if (hit && row_hit_cnt != '1) row_hit_cnt <= row_hit_cnt + 1'b1;
            if (conflict && row_conflict_cnt != '1) row_conflict_cnt <= row_conflict_cnt + 1'b1;
            if (ap && ap_cnt != '1) ap_cnt <= ap_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/backend_ap_dispatcher.sv
// backend_ap_dispatcher: in-order command queue feeding the slice controller with a per-command auto-precharge choice
// Ports: clk, power_on_rst_n (async, active-low); i_cmd_* / o_cmd_ready frontend valid-ready channel;
// o_ctrl_* / i_ctrl_ready slice-controller channel (queue head plus auto-precharge flag);
// o_row_hit_cnt, o_row_conflict_cnt, o_ap_cnt saturating issue statistics.
module backend_ap_dispatcher
    import backend_ap_dispatcher_pkg::*;
#(
    parameter int NUM_BANKS   = 8,
    parameter int ROW_BITS    = 14,
    parameter int COL_BITS    = 10,
    parameter int DATA_BITS   = 64,
    parameter int QUEUE_DEPTH = 4,
    parameter int AP_MODE     = 2,
    parameter int CNT_BITS    = 16,
    localparam int BANK_BITS  = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 power_on_rst_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_op,
    input  logic [BANK_BITS-1:0] i_cmd_bank,
    input  logic [ROW_BITS-1:0]  i_cmd_row,
    input  logic [COL_BITS-1:0]  i_cmd_col,
    input  logic [DATA_BITS-1:0] i_cmd_wdata,
    output logic                 o_ctrl_valid,
    input  logic                 i_ctrl_ready,
    output logic                 o_ctrl_op,
    output logic [BANK_BITS-1:0] o_ctrl_bank,
    output logic [ROW_BITS-1:0]  o_ctrl_row,
    output logic [COL_BITS-1:0]  o_ctrl_col,
    output logic [DATA_BITS-1:0] o_ctrl_wdata,
    output logic                 o_ctrl_auto_precharge,
    output logic [CNT_BITS-1:0]  o_row_hit_cnt,
    output logic [CNT_BITS-1:0]  o_row_conflict_cnt,
    output logic [CNT_BITS-1:0]  o_ap_cnt
);
    localparam int PTR_BITS = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_BITS:0] DEPTH = (PTR_BITS + 1)'(QUEUE_DEPTH);
    localparam ap_mode_t MODE = ap_mode_t'(AP_MODE[1:0]);

    typedef struct packed {
        logic                 op;
        logic [BANK_BITS-1:0] bank;
        logic [ROW_BITS-1:0]  row;
        logic [COL_BITS-1:0]  col;
        logic [DATA_BITS-1:0] wdata;
    } entry_t;

    entry_t              q [QUEUE_DEPTH];
    entry_t              head;
    logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
    logic [PTR_BITS:0]   count, count_next;
    logic                enq, deq, behind_match, ap;

    assign enq        = i_cmd_valid & o_cmd_ready;
    assign deq        = o_ctrl_valid & i_ctrl_ready;
    assign count_next = count + {{PTR_BITS{1'b0}}, enq} - {{PTR_BITS{1'b0}}, deq};
    assign head       = q[rd_ptr];

    always_ff @(posedge clk) begin
        if (enq) q[wr_ptr] <= '{op: i_cmd_op, bank: i_cmd_bank, row: i_cmd_row, col: i_cmd_col, wdata: i_cmd_wdata};
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_cmd_ready <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count       <= count_next;
            o_cmd_ready <= count_next < DEPTH;
        end
    end

    // Keep the head's row open only if a queued command behind it targets the same bank and row.
    always_comb begin
        behind_match = 1'b0;
        for (int i = 1; i < QUEUE_DEPTH; i++) begin
            if ((PTR_BITS + 1)'(i) < count && q[rd_ptr + PTR_BITS'(i)].bank == head.bank &&
                q[rd_ptr + PTR_BITS'(i)].row == head.row)
                behind_match = 1'b1;
        end
    end

    assign ap = (MODE == AP_CLOSE) || (MODE != AP_OPEN && !behind_match);

    // Payload is gated by valid so an empty or resetting queue presents zeros without clearing storage.
    assign o_ctrl_valid          = count != '0;
    assign o_ctrl_op             = o_ctrl_valid & head.op;
    assign o_ctrl_bank           = o_ctrl_valid ? head.bank : '0;
    assign o_ctrl_row            = o_ctrl_valid ? head.row : '0;
    assign o_ctrl_col            = o_ctrl_valid ? head.col : '0;
    assign o_ctrl_wdata          = o_ctrl_valid ? head.wdata : '0;
    assign o_ctrl_auto_precharge = o_ctrl_valid & ap;

    backend_bank_tracker #(
        .NUM_BANKS (NUM_BANKS),
        .ROW_BITS  (ROW_BITS),
        .CNT_BITS  (CNT_BITS)
    ) u_tracker (
        .clk              (clk),
        .power_on_rst_n   (power_on_rst_n),
        .issue            (deq),
        .bank             (head.bank),
        .row              (head.row),
        .ap               (ap),
        .row_hit_cnt      (o_row_hit_cnt),
        .row_conflict_cnt (o_row_conflict_cnt),
        .ap_cnt           (o_ap_cnt)
    );
endmodule

// File: tb/tb_backend_ap_dispatcher.sv
// tb_backend_ap_dispatcher: scoreboard bench driving three dispatchers (lookahead, always-close, always-open with 4-bit counters)
module tb_backend_ap_dispatcher;
    typedef struct {
        bit        op;
        bit [2:0]  bank;
        bit [13:0] row;
        bit [9:0]  col;
        bit [63:0] wdata;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic cmd_valid = 1'b0, cmd_op = 1'b0, ctrl_ready = 1'b0;
    logic [2:0]  cmd_bank = '0;
    logic [13:0] cmd_row = '0;
    logic [9:0]  cmd_col = '0;
    logic [63:0] cmd_wdata = '0;

    wire [2:0]        cmd_ready, ctrl_valid, ctrl_op, ctrl_ap;
    wire [2:0][2:0]   ctrl_bank;
    wire [2:0][13:0]  ctrl_row;
    wire [2:0][9:0]   ctrl_col;
    wire [2:0][63:0]  ctrl_wdata;
    wire [2:0][15:0]  hit_c, conf_c, apc_c;

    int total = 0, bad = 0;
    bit rnd = 0;
    ent_t exp_q[$];
    bit open_m[3][8];
    int orow_m[3][8];
    int hit_m[3], conf_m[3], apc_m[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CW = (g == 2) ? 4 : 16;
        wire [CW-1:0] h, c, a;
        backend_ap_dispatcher #(
            .AP_MODE  (g == 0 ? 2 : g == 1 ? 0 : 1),
            .CNT_BITS (CW)
        ) dut (
            .clk                   (clk),
            .power_on_rst_n        (rst_n),
            .i_cmd_valid           (cmd_valid),
            .o_cmd_ready           (cmd_ready[g]),
            .i_cmd_op              (cmd_op),
            .i_cmd_bank            (cmd_bank),
            .i_cmd_row             (cmd_row),
            .i_cmd_col             (cmd_col),
            .i_cmd_wdata           (cmd_wdata),
            .o_ctrl_valid          (ctrl_valid[g]),
            .i_ctrl_ready          (ctrl_ready),
            .o_ctrl_op             (ctrl_op[g]),
            .o_ctrl_bank           (ctrl_bank[g]),
            .o_ctrl_row            (ctrl_row[g]),
            .o_ctrl_col            (ctrl_col[g]),
            .o_ctrl_wdata          (ctrl_wdata[g]),
            .o_ctrl_auto_precharge (ctrl_ap[g]),
            .o_row_hit_cnt         (h),
            .o_row_conflict_cnt    (c),
            .o_ap_cnt              (a)
        );
        assign hit_c[g]  = 16'(h);
        assign conf_c[g] = 16'(c);
        assign apc_c[g]  = 16'(a);
    end

    function automatic int mode_of(int d);
        return d == 0 ? 2 : d == 1 ? 0 : 1;
    endfunction

    function automatic int cmax(int d);
        return d == 2 ? 15 : 65535;
    endfunction

    function automatic ent_t mk(bit op, int b, int r, int c, logic [63:0] w);
        ent_t e;
        e.op = op; e.bank = 3'(b); e.row = 14'(r); e.col = 10'(c); e.wdata = w;
        return e;
    endfunction

    // Close after this command unless something later in the queue wants the same row.
    function automatic bit model_ap(int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'b0;
        for (int i = 1; i < exp_q.size(); i++)
            if (exp_q[i].bank == exp_q[0].bank && exp_q[i].row == exp_q[0].row) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
        end
    endtask

    task automatic model_issue(input int d, input ent_t e, input bit ap);
        if (open_m[d][e.bank]) begin
            if (orow_m[d][e.bank] == int'(e.row)) hit_m[d] = (hit_m[d] < cmax(d)) ? hit_m[d] + 1 : hit_m[d];
            else conf_m[d] = (conf_m[d] < cmax(d)) ? conf_m[d] + 1 : conf_m[d];
        end
        if (ap) begin
            open_m[d][e.bank] = 1'b0;
            apc_m[d] = (apc_m[d] < cmax(d)) ? apc_m[d] + 1 : apc_m[d];
        end else begin
            open_m[d][e.bank] = 1'b1;
            orow_m[d][e.bank] = int'(e.row);
        end
    endtask

    // Monitor: every cycle compare each DUT with the reference, then retire the head on a handshake.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                hit_m[d] = 0; conf_m[d] = 0; apc_m[d] = 0;
                for (int b = 0; b < 8; b++) open_m[d][b] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                chk("valid", d, ctrl_valid[d], exp_q.size() != 0);
                chk("ready", d, cmd_ready[d], exp_q.size() < 4);
                chk("hit_cnt", d, hit_c[d], hit_m[d]);
                chk("conflict_cnt", d, conf_c[d], conf_m[d]);
                chk("ap_cnt", d, apc_c[d], apc_m[d]);
                if (exp_q.size() != 0) begin
                    chk("op", d, ctrl_op[d], exp_q[0].op);
                    chk("bank", d, ctrl_bank[d], exp_q[0].bank);
                    chk("row", d, ctrl_row[d], exp_q[0].row);
                    chk("col", d, ctrl_col[d], exp_q[0].col);
                    chk("wdata", d, ctrl_wdata[d], exp_q[0].wdata);
                    chk("ap", d, ctrl_ap[d], model_ap(mode_of(d)));
                end
            end
            if (ctrl_ready && exp_q.size() != 0) begin
                for (int d = 0; d < 3; d++) model_issue(d, exp_q[0], model_ap(mode_of(d)));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) ctrl_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input ent_t e);
        int n = 0;
        bit acc = 1'b0;
        cmd_valid = 1'b1; cmd_op = e.op; cmd_bank = e.bank; cmd_row = e.row; cmd_col = e.col; cmd_wdata = e.wdata;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = cmd_ready[0];
            tick();
            n++;
        end
        if (acc) exp_q.push_back(e);
        else begin
            total++; bad++;
            $display("FAIL send_timeout dut0: got no accept expected accept");
        end
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int n = 0;
        rnd = 0;
        cmd_valid = 1'b0;
        ctrl_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout dut0: got %0d queued expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", d, ctrl_valid[d], 0);
            chk("rst_ready", d, cmd_ready[d], 0);
            chk("rst_row", d, ctrl_row[d], 0);
            chk("rst_wdata", d, ctrl_wdata[d], 0);
            chk("rst_ap", d, ctrl_ap[d], 0);
            chk("rst_hit", d, hit_c[d], 0);
            chk("rst_conf", d, conf_c[d], 0);
            chk("rst_apcnt", d, apc_c[d], 0);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk("rel_ready_low", d, cmd_ready[d], 0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk("rel_ready_rise", d, cmd_ready[d], 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog dut0: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t e5;
        do_reset();

        // Reset mid-traffic: build up statistics, queue three commands, then reset.
        ctrl_ready = 1'b1;
        send(mk(0, 3, 5, 1, 64'h11)); idle(2);
        send(mk(1, 3, 5, 2, 64'h22)); idle(2);
        ctrl_ready = 1'b0;
        send(mk(0, 1, 1, 3, 64'h33));
        send(mk(1, 2, 2, 4, 64'h44));
        send(mk(0, 4, 3, 5, 64'h55));
        idle(1);
        do_reset();
        ctrl_ready = 1'b1;
        idle(6);

        // Fill and stall.
        do_reset();
        ctrl_ready = 1'b0;
        send(mk(1, 6, 'h2a, 'h3f, 64'hdead_beef_0000_0001));
        send(mk(0, 2, 'h10, 'h01, 64'h0123_4567_89ab_cdef));
        send(mk(1, 7, 'h3fff, 'h3ff, 64'hffff_ffff_ffff_ffff));
        send(mk(0, 0, 0, 0, 64'h0));
        for (int d = 0; d < 3; d++) chk("full_ready", d, cmd_ready[d], 0);
        e5 = mk(0, 5, 'h77, 'h12, 64'h5555_aaaa_5555_aaaa);
        cmd_valid = 1'b1; cmd_op = e5.op; cmd_bank = e5.bank; cmd_row = e5.row; cmd_col = e5.col; cmd_wdata = e5.wdata;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("stall_ready", 0, cmd_ready[0], 0);
        end
        chk("stall_row", 0, ctrl_row[0], 'h2a);
        chk("stall_wdata", 0, ctrl_wdata[0], 64'hdead_beef_0000_0001);
        ctrl_ready = 1'b1;
        send(e5);
        drain();

        // Lookahead.
        do_reset();
        ctrl_ready = 1'b0;
        send(mk(0, 2, 'h100, 1, 64'ha1));
        send(mk(1, 5, 7, 2, 64'ha2));
        send(mk(0, 2, 'h100, 3, 64'ha3));
        idle(1);
        chk("look_head_ap", 0, ctrl_ap[0], 0);
        drain();
        chk("look_hit", 0, hit_c[0], 1);
        chk("look_apcnt", 0, apc_c[0], 2);

        // AP falls while stalled.
        do_reset();
        ctrl_ready = 1'b0;
        send(mk(0, 1, 9, 4, 64'hb1));
        idle(3);
        chk("fall_before", 0, ctrl_ap[0], 1);
        send(mk(1, 1, 9, 5, 64'hb2));
        chk("fall_after", 0, ctrl_ap[0], 0);
        idle(6);
        chk("fall_hold", 0, ctrl_ap[0], 0);
        drain();

        // Fixed policies, conflict and saturation.
        do_reset();
        ctrl_ready = 1'b1;
        repeat (4) begin
            send(mk(0, 0, 3, 7, 64'hc3));
            idle(2);
        end
        drain();
        chk("close_apcnt", 1, apc_c[1], 4);
        chk("close_hit", 1, hit_c[1], 0);
        chk("open_apcnt", 2, apc_c[2], 0);
        chk("open_hit", 2, hit_c[2], 3);
        send(mk(1, 0, 4, 8, 64'hc4));
        drain();
        chk("open_conflict", 2, conf_c[2], 1);
        chk("close_conflict", 1, conf_c[1], 0);
        repeat (20) begin
            send(mk(0, 0, 4, 9, 64'hc5));
            idle(1);
        end
        drain();
        chk("sat_hit", 2, hit_c[2], 15);

        // Random traffic.
        do_reset();
        rnd = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            else send(mk(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1023),
                         {$urandom, $urandom}));
        end
        drain();
        for (int d = 0; d < 3; d++) begin
            chk("end_hit", d, hit_c[d], hit_m[d]);
            chk("end_conf", d, conf_c[d], conf_m[d]);
            chk("end_apcnt", d, apc_c[d], apc_m[d]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/backend_ap_dispatcher.md
Name: backend_ap_dispatcher

Overview:
- Parametrised successor to the single-rank, bank-0, always-auto-precharge backend command path.
- Sits between the frontend command channel and the DDR3 slice controller (`Ctrl`).
- Buffers frontend commands in an in-order queue and issues them to any of NUM_BANKS banks.
- Decides auto-precharge per command via a configurable lookahead predictor, tracks open rows per bank and keeps row-hit and precharge statistics.

Parameters:
- NUM_BANKS, 8, banks addressed; power of two; BANK_BITS = $clog2(NUM_BANKS) is a localparam.
- ROW_BITS, 14, row address width.
- COL_BITS, 10, column address width.
- DATA_BITS, 64, write-data width (DQ_BITS*8).
- QUEUE_DEPTH, 4, command queue entries; power of two, ≥2.
- AP_MODE, 2, auto-precharge policy: 0 = always close, 1 = always open, 2 = lookahead.
- CNT_BITS, 16, statistics counter width.

Ports:
- clk  in  1  system clock
- power_on_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  frontend command valid
- o_cmd_ready  out  1  queue can accept a command
- i_cmd_op  in  1  0 = write, 1 = read (r_w encoding)
- i_cmd_bank  in  BANK_BITS  target bank
- i_cmd_row  in  ROW_BITS  target row
- i_cmd_col  in  COL_BITS  target column
- i_cmd_wdata  in  DATA_BITS  write data, ignored for reads
- o_ctrl_valid  out  1  head command presented to slice controller
- i_ctrl_ready  in  1  slice controller accepts (ba_cmd_pm)
- o_ctrl_op  out  1  head op
- o_ctrl_bank  out  BANK_BITS  head bank
- o_ctrl_row  out  ROW_BITS  head row
- o_ctrl_col  out  COL_BITS  head column
- o_ctrl_wdata  out  DATA_BITS  head write data
- o_ctrl_auto_precharge  out  1  auto-precharge flag for head
- o_row_hit_cnt  out  CNT_BITS  issued commands that hit an open row
- o_row_conflict_cnt  out  CNT_BITS  issued commands to a bank open on a different row
- o_ap_cnt  out  CNT_BITS  commands issued with auto-precharge = 1

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on power_on_rst_n.
- Reset clears:
  - wr_ptr, rd_ptr and count;
  - all per-bank open flags;
  - all three counters, to 0.
- Outputs during reset:
  - o_cmd_ready = 0 and o_ctrl_valid = 0;
  - all o_ctrl_* payload outputs = 0.
- o_cmd_ready is registered and rises at the first clk edge after reset release.
- Reset mid-operation discards all queued commands with no issue.
- Enqueue: on i_cmd_valid & o_cmd_ready at a rising edge, write the entry at wr_ptr.
- Dequeue: on o_ctrl_valid & i_ctrl_ready, advance rd_ptr.
- Pointers wrap modulo QUEUE_DEPTH. count is incremented, decremented or held on simultaneous enqueue and dequeue.
- o_cmd_ready (registered) = (count_next < QUEUE_DEPTH).
  - When full, ready stays 0 even if a dequeue occurs that cycle; there is no full-bypass, and ready rises the following cycle.
- o_ctrl_valid = (count != 0). Payload outputs are driven combinationally from the entry at rd_ptr.
- Latency: a command enqueued at edge N into an empty queue is presented from cycle N+1. There is no empty-bypass.
- Payload op, bank, row, col and wdata are stable while o_ctrl_valid & !i_ctrl_ready.
- Auto-precharge decision, evaluated combinationally every cycle:
  - AP_MODE 0 → 1.
  - AP_MODE 1 → 0.
  - AP_MODE 2 → 0 if any valid entry behind the head has the same bank and same row; otherwise 1. The head itself and the current-cycle incoming command are excluded.
- AP stability: in mode 2 the flag may only fall 1→0 while stalled (a matching entry enqueues), never 0→1, because entries behind the head cannot leave first.
- Open-row tracker: per bank, an open flag plus an open_row register. On each issue:
  - hit if open & open_row == row → o_row_hit_cnt++;
  - conflict if open & open_row != row → o_row_conflict_cnt++;
  - if AP=1: clear open and o_ap_cnt++; otherwise set open and open_row = row.
- Counters saturate at all-ones and do not wrap.
- Widths: all comparisons are unsigned full-width. There is no truncation.

Decomposition:
- Shared package (alongside the frontend command package):
  - ap_mode_t enum (AP_CLOSE, AP_OPEN, AP_LOOKAHEAD);
  - dispatch_entry_t struct (op, bank, row, col, wdata).
- One sub-module is natural: backend_bank_tracker.
  - It holds the per-bank open flags, open_row registers and the three saturating counters.
  - It takes issue strobe, bank, row and AP flag as inputs.
- Queue and lookahead compare stay in the top module.

Test Plan:
- Reset and ready:
  - Assert power_on_rst_n low mid-traffic with 3 entries queued → o_ctrl_valid=0 immediately, counters=0.
  - After release → o_cmd_ready=1 one edge later; the stale entries are never issued.
- Fill and stall:
  - AP_MODE=2, i_ctrl_ready=0, enqueue 5 commands → o_cmd_ready=0 after the 4th.
  - The 5th is held. Payload stays constant for 20 stall cycles.
- Lookahead:
  - Enqueue (bank2,row0x100), (bank5,row7), (bank2,row0x100) → head AP=0.
  - Second issue AP=1. Third issue AP=1 and o_row_hit_cnt=1.
- AP fall while stalled:
  - Head (bank1,row9) stalled with AP=1, then enqueue (bank1,row9) → AP falls to 0 next cycle and never returns to 1 before issue.
- Modes 0/1:
  - 4 issues of (bank0,row3) with AP_MODE=0 → o_ap_cnt=4, o_row_hit_cnt=0.
  - Same with AP_MODE=1 → o_ap_cnt=0, o_row_hit_cnt=3.
  - Then (bank0,row4) → o_row_conflict_cnt=1.
- Saturation, CNT_BITS=4:
  - 20 row hits → o_row_hit_cnt holds at 15.
